// File: rtl/exp_series_engine.sv
// Batch exp(x) engine: reads n samples, evaluates a TERMS-term Taylor series per sample by Horner MAC,
// writes each result back; optional single-step pacing advances one sample per step rising edge.
module exp_series_engine #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 21,
  parameter int TERMS  = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  n_samples,
  input  logic              step_mode,
  input  logic              step,
  output logic              rd_req,
  output logic [CNT_W-1:0]  rd_addr,
  input  logic              rd_ack,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_req,
  output logic [CNT_W-1:0]  wr_addr,
  output logic [OUT_W-1:0]  wr_data,
  input  logic              wr_ack,
  output logic              busy,
  output logic              done
);
  typedef enum logic [2:0] {IDLE, WAIT_STEP, READ, CALC, WRITE, DONE} state_t;
  typedef logic [TERMS-1:0][OUT_W-1:0] coef_t;
  localparam int K_W = $clog2(TERMS);

  // c[k] = floor(2^DATA_W / k!), folded to constants at elaboration
  function automatic coef_t init_coef();
    coef_t c;
    longint unsigned f;
    f = 1;
    for (int i = 0; i < TERMS; i++) begin
      if (i > 0) f = f * longint'(i);
      c[i] = OUT_W'((64'd1 << DATA_W) / f);
    end
    return c;
  endfunction

  localparam coef_t COEF = init_coef();

  state_t                    state, nxt;
  logic [CNT_W-1:0]          n_lat, idx, last;
  logic                      step_lat, step_q, step_rise;
  logic [DATA_W-1:0]         x;
  logic [OUT_W-1:0]          acc;
  logic [K_W-1:0]            k;
  logic [OUT_W+DATA_W-1:0]   prod;

  assign step_rise = step & ~step_q;
  assign last      = n_lat - CNT_W'(1);   // n=0 wraps to all-ones, i.e. 2^CNT_W samples
  assign prod      = {{DATA_W{1'b0}}, acc} * {{OUT_W{1'b0}}, x};
  assign rd_addr   = idx;
  assign wr_addr   = idx;
  assign wr_data   = acc;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:      if (start) nxt = step_mode ? WAIT_STEP : READ;
      WAIT_STEP: if (step_rise) nxt = READ;
      READ:      if (rd_ack) nxt = CALC;
      CALC:      if (k == '0) nxt = WRITE;
      WRITE:     if (wr_ack) nxt = (idx == last) ? DONE : (step_lat ? WAIT_STEP : READ);
      DONE:      nxt = IDLE;
      default:   nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_req   <= 1'b0;
      wr_req   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      step_q   <= 1'b0;
      n_lat    <= '0;
      step_lat <= 1'b0;
      idx      <= '0;
      x        <= '0;
      acc      <= '0;
      k        <= '0;
    end else begin
      rd_req <= (nxt == READ);
      wr_req <= (nxt == WRITE);
      busy   <= (nxt != IDLE);
      done   <= (nxt == DONE);
      step_q <= step;
      case (state)
        IDLE: if (start) begin
          n_lat    <= n_samples;
          step_lat <= step_mode;
          idx      <= '0;
        end
        READ: if (rd_ack) begin
          x   <= rd_data;
          acc <= COEF[TERMS-1];
          k   <= K_W'(TERMS-2);
        end
        CALC: begin
          acc <= COEF[k] + OUT_W'(prod >> DATA_W);
          if (k != '0) k <= k - K_W'(1);
        end
        WRITE: if (wr_ack && idx != last) idx <= idx + CNT_W'(1);
        default: ;
      endcase
    end
  end
endmodule
